// File: rtl/decode_execute_if.sv
// Fetch <-> decode/execute link: instruction word forward, jump request back.
// master = fetch side, slave = decode/execute side.
interface decode_execute_if #(
    parameter int DW = 4
);
    logic [2*DW-1:0] inst;
    logic            isjump;
    logic [DW-1:0]   jumpadrs;

    modport master (
        output inst,
        input  isjump,
        input  jumpadrs
    );

    modport slave (
        input  inst,
        output isjump,
        output jumpadrs
    );
endinterface

// File: rtl/decode_execute.sv
// decode_execute: single-cycle decode/execute stage of a tiny 4-bit core.
// Holds A, B, OUT and carry; returns the combinational jump request to fetch.
// Optional build macro DEXEC_INSYNC_EN: route in_port through a 2-flop
// synchronizer before the IN instructions see it.
module decode_execute #(
    parameter int            DW      = 4,
    parameter logic [DW-1:0] OUT_RST = {DW{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    decode_execute_if.slave  fe,
    input  logic [DW-1:0]    in_port,
    output logic [DW-1:0]    out_port,
    output logic [DW-1:0]    reg_a,
    output logic [DW-1:0]    reg_b,
    output logic             carry
);

    localparam logic [DW-1:0] OP_ADD_A = DW'(4'b0000);
    localparam logic [DW-1:0] OP_MOV_AB = DW'(4'b0001);
    localparam logic [DW-1:0] OP_IN_A  = DW'(4'b0010);
    localparam logic [DW-1:0] OP_MOV_AI = DW'(4'b0011);
    localparam logic [DW-1:0] OP_MOV_BA = DW'(4'b0100);
    localparam logic [DW-1:0] OP_ADD_B = DW'(4'b0101);
    localparam logic [DW-1:0] OP_IN_B  = DW'(4'b0110);
    localparam logic [DW-1:0] OP_MOV_BI = DW'(4'b0111);
    localparam logic [DW-1:0] OP_OUT_B = DW'(4'b1001);
    localparam logic [DW-1:0] OP_OUT_I = DW'(4'b1011);
    localparam logic [DW-1:0] OP_JNC   = DW'(4'b1110);
    localparam logic [DW-1:0] OP_JMP   = DW'(4'b1111);

    // Adder with carry-out in the top bit of the result.
    function automatic logic [DW:0] add_cy(input logic [DW-1:0] x, input logic [DW-1:0] y);
        add_cy = {1'b0, x} + {1'b0, y};
    endfunction

    logic [DW-1:0] a_r, b_r, out_r;
    logic          carry_r;
    logic [DW-1:0] a_nxt_s, b_nxt_s, out_nxt_s;
    logic          carry_nxt_s;
    logic          isjump_s;
    logic [DW-1:0] op_s, imm_s, in_s;

    assign op_s  = fe.inst[2*DW-1:DW];
    assign imm_s = fe.inst[DW-1:0];

`ifdef DEXEC_INSYNC_EN
    logic [DW-1:0] sync1_r, sync2_r;

    // Two-stage synchronizer for the asynchronous input port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= {DW{1'b0}};
            sync2_r <= {DW{1'b0}};
        end else begin
            sync1_r <= in_port;
            sync2_r <= sync1_r;
        end
    end

    assign in_s = sync2_r;
`else
    assign in_s = in_port;
`endif

    // Decode the instruction into next architectural state and jump request.
    always_comb begin
        a_nxt_s     = a_r;
        b_nxt_s     = b_r;
        out_nxt_s   = out_r;
        carry_nxt_s = 1'b0;          // every non-ADD instruction clears carry
        isjump_s    = 1'b0;
        case (op_s)
            OP_ADD_A:  {carry_nxt_s, a_nxt_s} = add_cy(a_r, imm_s);
            OP_ADD_B:  {carry_nxt_s, b_nxt_s} = add_cy(b_r, imm_s);
            OP_MOV_AI: a_nxt_s   = imm_s;
            OP_MOV_BI: b_nxt_s   = imm_s;
            OP_MOV_AB: a_nxt_s   = b_r;
            OP_MOV_BA: b_nxt_s   = a_r;
            OP_IN_A:   a_nxt_s   = in_s;
            OP_IN_B:   b_nxt_s   = in_s;
            OP_OUT_B:  out_nxt_s = b_r;
            OP_OUT_I:  out_nxt_s = imm_s;
            OP_JMP:    isjump_s  = 1'b1;
            OP_JNC:    isjump_s  = ~carry_r;   // flag left by the previous instruction
            default:   isjump_s  = 1'b0;       // NOP encodings
        endcase
    end

    // Architectural state register; reset clears everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r     <= {DW{1'b0}};
            b_r     <= {DW{1'b0}};
            out_r   <= OUT_RST;
            carry_r <= 1'b0;
        end else begin
            a_r     <= a_nxt_s;
            b_r     <= b_nxt_s;
            out_r   <= out_nxt_s;
            carry_r <= carry_nxt_s;
        end
    end

    // Fetch must not jump while the core is held in reset.
    assign fe.isjump   = rst & isjump_s;
    assign fe.jumpadrs = imm_s;

    assign reg_a    = a_r;
    assign reg_b    = b_r;
    assign out_port = out_r;
    assign carry    = carry_r;

endmodule

// File: tb/tb_decode_execute.sv
// Self-checking bench for decode_execute with a behavioural ISA model.
module tb_decode_execute;

`ifdef DEXEC_INSYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] in_port;
    logic [3:0] out_port, reg_a, reg_b;
    logic       carry;
    int         errors;
    int         checks;

    // Model state (plain integers, ISA-level semantics)
    int ma, mb, mo, mc, h1, h2;

    decode_execute_if #(.DW(4)) fe_if ();

    decode_execute #(.DW(4), .OUT_RST(4'h0)) dut (
        .clk      (clk),
        .rst      (rst),
        .fe       (fe_if.slave),
        .in_port  (in_port),
        .out_port (out_port),
        .reg_a    (reg_a),
        .reg_b    (reg_b),
        .carry    (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        ma = 0; mb = 0; mo = 0; mc = 0; h1 = 0; h2 = 0;
    endtask

    // One retired instruction per rising edge.
    task automatic model_edge(input logic [7:0] i, input logic [3:0] p);
        int op, im, src, s, nc;
        op = int'(i[7:4]);
        im = int'(i[3:0]);
        src = SYNC ? h2 : int'(p);
        h2 = h1;
        h1 = int'(p);
        nc = 0;
        case (op)
            0:  begin s = ma + im; ma = s % 16; nc = (s > 15) ? 1 : 0; end
            5:  begin s = mb + im; mb = s % 16; nc = (s > 15) ? 1 : 0; end
            3:  ma = im;
            7:  mb = im;
            1:  ma = mb;
            4:  mb = ma;
            2:  ma = src;
            6:  mb = src;
            9:  mo = mb;
            11: mo = im;
            default: ;
        endcase
        mc = nc;
    endtask

    function automatic logic exp_jump(input logic [7:0] i);
        return (i[7:4] == 4'hF) || (i[7:4] == 4'hE && mc == 0);
    endfunction

    task automatic drive(input logic [7:0] i, input logic [3:0] p);
        @(negedge clk);
        fe_if.inst = i;
        in_port    = p;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(fe_if.inst, in_port);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        fe_if.inst = {4'hF, 4'($urandom_range(0, 15))};
        in_port = 4'($urandom_range(0, 15));
        model_reset();
        #3;
        checks++;
        if (reg_a !== 4'h0 || reg_b !== 4'h0 || carry !== 1'b0 || out_port !== 4'h0) begin
            errors++;
            $display("FAIL reset_state a=%h b=%h c=%b out=%h required 0 0 0 0", reg_a, reg_b, carry, out_port);
        end
        checks++;
        if (fe_if.isjump !== 1'b0) begin
            errors++;
            $display("FAIL reset_isjump got %b required 0", fe_if.isjump);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        fe_if.inst = 8'h80;
        rst = 1'b1;
        #2;
        checks++;
        if (reg_a !== 4'h0 || reg_b !== 4'h0 || carry !== 1'b0 || out_port !== 4'h0) begin
            errors++;
            $display("FAIL reset_release_hold a=%h b=%h c=%b out=%h required 0 0 0 0", reg_a, reg_b, carry, out_port);
        end
    endtask

    task automatic test_add_carry();
        drive(8'h33, 4'h0); tick();
        drive(8'h0E, 4'h0); tick();
        checks++;
        if (reg_a !== 4'h1 || carry !== 1'b1) begin
            errors++;
            $display("FAIL add_wrap a=%h c=%b required a=1 c=1", reg_a, carry);
        end
        drive(8'hE5, 4'h0);
        checks++;
        if (fe_if.isjump !== 1'b0) begin
            errors++;
            $display("FAIL jnc_carry_set isjump=%b required 0", fe_if.isjump);
        end
        tick();
        checks++;
        if (carry !== 1'b0) begin
            errors++;
            $display("FAIL jnc_clears_carry c=%b required 0", carry);
        end
    endtask

    task automatic test_jump();
        drive(8'h77, 4'h0); tick();
        checks++;
        if (reg_b !== 4'h7) begin
            errors++;
            $display("FAIL mov_b_imm b=%h required 7", reg_b);
        end
        drive(8'hE9, 4'h0);
        checks++;
        if (fe_if.isjump !== 1'b1 || fe_if.jumpadrs !== 4'h9) begin
            errors++;
            $display("FAIL jnc_taken isjump=%b adr=%h required 1 9", fe_if.isjump, fe_if.jumpadrs);
        end
        tick();
        drive(8'hF2, 4'h0);
        checks++;
        if (fe_if.isjump !== 1'b1 || fe_if.jumpadrs !== 4'h2) begin
            errors++;
            $display("FAIL jmp isjump=%b adr=%h required 1 2", fe_if.isjump, fe_if.jumpadrs);
        end
        tick();
    endtask

    task automatic test_moves_out();
        drive(8'h3A, 4'h0); tick();
        drive(8'h40, 4'h0); tick();
        checks++;
        if (reg_b !== 4'hA || reg_a !== 4'hA) begin
            errors++;
            $display("FAIL mov_b_a a=%h b=%h required A A", reg_a, reg_b);
        end
        drive(8'h90, 4'h0); tick();
        checks++;
        if (out_port !== 4'hA) begin
            errors++;
            $display("FAIL out_b out=%h required A", out_port);
        end
        drive(8'hB6, 4'h0); tick();
        checks++;
        if (out_port !== 4'h6) begin
            errors++;
            $display("FAIL out_imm out=%h required 6", out_port);
        end
    endtask

    task automatic test_in_port();
        logic [3:0] exp_b;
        drive(8'h80, 4'h3); tick();
        drive(8'h80, 4'h3); tick();
        drive(8'h60, 4'hC); tick();
        exp_b = SYNC ? 4'h3 : 4'hC;
        checks++;
        if (reg_b !== exp_b) begin
            errors++;
            $display("FAIL in_b_fresh b=%h required %h", reg_b, exp_b);
        end
        drive(8'h80, 4'hC); tick();
        drive(8'h20, 4'hC); tick();
        checks++;
        if (reg_a !== 4'hC) begin
            errors++;
            $display("FAIL in_a_stable a=%h required C", reg_a);
        end
    endtask

    task automatic test_reset_midcycle();
        drive(8'h35, 4'h0); tick();
        drive(8'h7F, 4'h0); tick();
        drive(8'h51, 4'h0); tick();
        checks++;
        if (reg_b !== 4'h0 || carry !== 1'b1) begin
            errors++;
            $display("FAIL add_b_wrap b=%h c=%b required 0 1", reg_b, carry);
        end
        drive(8'hF3, 4'h0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (reg_a !== 4'h0 || reg_b !== 4'h0 || carry !== 1'b0 || fe_if.isjump !== 1'b0) begin
            errors++;
            $display("FAIL midcycle_reset a=%h b=%h c=%b j=%b required 0 0 0 0", reg_a, reg_b, carry, fe_if.isjump);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(8'h80, 4'h0); tick();
        checks++;
        if (reg_a !== 4'h0 || reg_b !== 4'h0 || carry !== 1'b0 || out_port !== 4'h0) begin
            errors++;
            $display("FAIL nop_after_reset a=%h b=%h c=%b out=%h required 0 0 0 0", reg_a, reg_b, carry, out_port);
        end
    endtask

    task automatic test_random();
        logic [7:0] i;
        logic [3:0] p;
        logic       ej;
        for (int n = 0; n < 300; n++) begin
            i = 8'($urandom_range(0, 255));
            p = 4'($urandom_range(0, 15));
            drive(i, p);
            ej = exp_jump(i);
            checks++;
            if (fe_if.isjump !== ej || (ej && fe_if.jumpadrs !== i[3:0])) begin
                errors++;
                $display("FAIL rand_jump inst=%h isjump=%b adr=%h required %b %h", i, fe_if.isjump, fe_if.jumpadrs, ej, i[3:0]);
            end
            tick();
            checks++;
            if (reg_a !== ma[3:0] || reg_b !== mb[3:0] || out_port !== mo[3:0] || carry !== mc[0]) begin
                errors++;
                $display("FAIL rand_state inst=%h a=%h b=%h out=%h c=%b required %h %h %h %b",
                         i, reg_a, reg_b, out_port, carry, ma[3:0], mb[3:0], mo[3:0], mc[0]);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        fe_if.inst = 8'h80;
        in_port = 4'h0;
        test_reset();
        test_add_carry();
        test_jump();
        test_moves_out();
        test_in_port();
        test_reset_midcycle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
